// File: rtl/armv8_pkg.sv
// Shared ARMv8 datapath constants: multiplier state encoding and iteration bound.
package armv8_pkg;

  localparam logic [1:0] MUL_IDLE = 2'd0;
  localparam logic [1:0] MUL_RUN  = 2'd1;
  localparam logic [1:0] MUL_DONE = 2'd2;

  localparam logic [5:0] MUL_ITER_LAST = 6'd63;

endpackage

// File: rtl/CLA_64bit.sv
// 64-bit carry-lookahead adder: 4-bit lookahead groups chained by group generate/propagate.
module CLA_64bit (
  output logic [63:0] F,
  output logic        C_out,
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic        C_in
);

  localparam int unsigned GROUPS = 16;

  logic [63:0] g;
  logic [63:0] p;
  logic        carry;
  logic        c1;
  logic        c2;
  logic        c3;
  logic        gg;
  logic        pg;

  assign g = A & B;
  assign p = A ^ B;

  always_comb begin
    F     = '0;
    carry = C_in;
    c1    = 1'b0;
    c2    = 1'b0;
    c3    = 1'b0;
    gg    = 1'b0;
    pg    = 1'b0;
    for (int k = 0; k < int'(GROUPS); k++) begin
      c1 = g[4*k] | (p[4*k] & carry);
      c2 = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & carry);
      c3 = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
         | (p[4*k+2] & p[4*k+1] & p[4*k] & carry);
      gg = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
         | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pg = &p[4*k +: 4];
      F[4*k +: 4] = p[4*k +: 4] ^ {c3, c2, c1, carry};
      carry = gg | (pg & carry);
    end
    C_out = carry;
  end

endmodule

// File: rtl/mul_seq_64.sv
// Sequential unsigned 64x64->128 shift-add multiplier; one CLA_64bit add per cycle, 65-cycle latency.
module mul_seq_64
  import armv8_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] P_lo,
  output logic [WIDTH-1:0] P_hi
);

  logic [1:0]         state;
  logic [1:0]         state_next;
  logic               accept;
  logic [WIDTH-1:0]   m;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   q;
  logic [5:0]         cnt;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic [2*WIDTH-1:0] shifted;

  // Next-state logic; encoding 2'd3 falls back to IDLE.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      MUL_IDLE: begin
        if (start) begin
          state_next = MUL_RUN;
          accept     = 1'b1;
        end
      end
      MUL_RUN: begin
        if (cnt == MUL_ITER_LAST) state_next = MUL_DONE;
      end
      MUL_DONE: begin
        if (start) begin
          state_next = MUL_RUN;
          accept     = 1'b1;
        end else begin
          state_next = MUL_IDLE;
        end
      end
      default: state_next = MUL_IDLE;
    endcase
  end

  assign addend = q[0] ? m : '0;

  CLA_64bit u_cla (sum, carry, acc, addend, 1'b0);

  // Adder result plus the multiplier tail form the 129-bit right shift of {C_out, F, Q}.
  assign shifted = {carry, sum, q[WIDTH-1:1]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= MUL_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == MUL_RUN);
      done  <= (state_next == MUL_DONE);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      m    <= '0;
      acc  <= '0;
      q    <= '0;
      cnt  <= '0;
      P_lo <= '0;
      P_hi <= '0;
    end else if (accept) begin
      m   <= A;
      q   <= B;
      acc <= '0;
      cnt <= '0;
    end else if (state == MUL_RUN) begin
      {acc, q} <= shifted;
      cnt      <= cnt + 6'd1;
      if (state_next == MUL_DONE) {P_hi, P_lo} <= shifted;
    end
  end

endmodule
